// File: rtl/mult_div_pkg.sv
// Shared encodings and sizes for the sequential multiplier/divider pair.
package mult_div_pkg;
    localparam int WORD = 32;
    localparam int ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration: add/sub the multiplicand, then arithmetic-shift {acc,q,q_1}.
module booth_step #(
    parameter int W = 32
) (
    input  logic [W:0]   acc,
    input  logic [W-1:0] q,
    input  logic         q_1,
    input  logic [W:0]   mcand,
    output logic [W:0]   acc_n,
    output logic [W-1:0] q_n,
    output logic         q_1_n
);
    logic [W:0] sum;

    always_comb begin
        sum = acc;
        case ({q[0], q_1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
    end

    // Sign bit of the accumulator is replicated on the way in; old q_1 falls off the end.
    assign {acc_n, q_n, q_1_n} = {sum[W], sum, q};
endmodule

// File: rtl/mult.sv
// Sequential signed Booth multiplier: one step per clock, result published in DONE.
module mult
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WORD
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             MultStart,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             MultDone
);
    localparam int STEPS = (WIDTH == WORD) ? ITER : WIDTH;
    localparam int CW    = $clog2(STEPS);

    state_t           state;
    logic [WIDTH:0]   acc, mcand, acc_n;
    logic [WIDTH-1:0] q, q_n;
    logic             q_1, q_1_n;
    logic [CW-1:0]    cnt;

    booth_step #(.W(WIDTH)) u_step (
        .acc   (acc),
        .q     (q),
        .q_1   (q_1),
        .mcand (mcand),
        .acc_n (acc_n),
        .q_n   (q_n),
        .q_1_n (q_1_n)
    );

    assign busy = (state == LOAD) || (state == RUN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            q        <= '0;
            q_1      <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            MultDone <= 1'b0;
        end else begin
            MultDone <= 1'b0;
            case (state)
                IDLE: if (MultStart) begin
                    // Operands are captured here so later changes on A/B cannot leak in.
                    acc   <= '0;
                    q     <= B;
                    q_1   <= 1'b0;
                    mcand <= {A[WIDTH-1], A};
                    cnt   <= '0;
                    state <= LOAD;
                end
                LOAD: state <= RUN;
                RUN: begin
                    acc <= acc_n;
                    q   <= q_n;
                    q_1 <= q_1_n;
                    if (cnt == CW'(STEPS - 1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    hi       <= acc[WIDTH-1:0];
                    lo       <= q;
                    MultDone <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult.sv
// Self-checking bench for mult: directed vector table, corner sequences, random vs. 64-bit model.
module tb_mult;
    logic        clock, reset, MultStart;
    logic [31:0] A, B, hi, lo;
    logic        busy, MultDone;

    int errs  = 0;
    int nchk  = 0;

    mult #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .MultStart (MultStart),
        .A         (A),
        .B         (B),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .MultDone  (MultDone)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact signed 64-bit product by plain arithmetic.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    // Issues one start pulse, scrambles A/B while running, and measures the handshake.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] p, output int lat, output int bc,
                           output int dw, output bit hold_ok);
        logic [63:0] prev;
        int k;
        prev = {hi, lo};
        hold_ok = 1'b1;
        p = '0; lat = -1; bc = 0; dw = 0; k = 0;
        @(negedge clock);
        A = a; B = b; MultStart = 1'b1;
        @(posedge clock); #1;
        MultStart = 1'b0;
        while (k < 60 && lat < 0) begin
            if (busy) bc++;
            A = $urandom; B = $urandom;
            @(posedge clock); #1;
            k++;
            if (MultDone) begin
                lat = k;
                p = {hi, lo};
            end else if ({hi, lo} !== prev) begin
                hold_ok = 1'b0;
            end
        end
        if (lat >= 0) begin
            @(posedge clock); #1;
            dw = MultDone ? 2 : 1;
        end
    endtask

    task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp, input bit full);
        logic [63:0] p;
        int lat, bc, dw;
        bit hold_ok;
        do_mult(a, b, p, lat, bc, dw, hold_ok);
        check({name, " product"}, p, exp);
        check({name, " done width"}, 64'(dw), 64'd1);
        if (full) begin
            check({name, " latency"}, 64'(lat), 64'd34);
            check({name, " busy cycles"}, 64'(bc), 64'd33);
            check({name, " hold"}, 64'(hold_ok), 64'd1);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        int k, lat, bc;
        logic [63:0] p;
        bit saw_done;

        tbl[0] = '{"6x7",        32'd6,          32'd7,          64'h0000_0000_0000_002A};
        tbl[1] = '{"m1x1",       32'hFFFF_FFFF,  32'd1,          64'hFFFF_FFFF_FFFF_FFFF};
        tbl[2] = '{"minxmin",    32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
        tbl[3] = '{"minxmax",    32'h8000_0000,  32'h7FFF_FFFF,  64'hC000_0000_8000_0000};
        tbl[4] = '{"0xk",        32'd0,          32'h1234_5678,  64'h0};
        tbl[5] = '{"kx0",        32'hDEAD_BEEF,  32'd0,          64'h0};
        tbl[6] = '{"m1xm1",      32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h1};
        tbl[7] = '{"maxxmax",    32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001};
        tbl[8] = '{"kxm1",       32'h1234_5678,  32'hFFFF_FFFF,  64'hFFFF_FFFF_EDCB_A988};
        tbl[9] = '{"m3x4",       32'hFFFF_FFFD,  32'd4,          64'hFFFF_FFFF_FFFF_FFF4};

        reset = 1'b0; MultStart = 1'b0; A = '0; B = '0;
        #23;
        check("reset hi", 64'(hi), 64'h0);
        check("reset lo", 64'(lo), 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        check("reset done", 64'(MultDone), 64'h0);
        @(negedge clock);
        reset = 1'b1;

        foreach (tbl[i]) run_check(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].p, 1'b1);

        // Start requests mid-run and in DONE must be dropped.
        @(negedge clock);
        A = 32'd3; B = 32'd5; MultStart = 1'b1;
        @(posedge clock); #1;
        MultStart = 1'b0;
        k = 0; bc = 0; lat = -1; p = '0;
        while (k < 60 && lat < 0) begin
            if (busy) bc++;
            if (k == 10) begin A = 32'd9; B = 32'd9; end
            MultStart = (k == 10 || k == 33);
            @(posedge clock); #1;
            k++;
            if (MultDone) begin lat = k; p = {hi, lo}; end
        end
        MultStart = 1'b0;
        check("ignore product", p, 64'h0000_0000_0000_000F);
        check("ignore latency", 64'(lat), 64'd34);
        check("ignore busy cycles", 64'(bc), 64'd33);
        @(posedge clock); #1;
        check("no restart from done", 64'(busy), 64'h0);

        // Asynchronous reset in the middle of RUN aborts without a done pulse.
        @(negedge clock);
        A = 32'd100; B = 32'd100; MultStart = 1'b1;
        @(posedge clock); #1;
        MultStart = 1'b0;
        repeat (15) begin @(posedge clock); #1; end
        #2 reset = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'h0);
        check("abort hilo", {hi, lo}, 64'h0);
        check("abort done", 64'(MultDone), 64'h0);
        saw_done = 1'b0;
        repeat (3) begin @(posedge clock); #1; if (MultDone) saw_done = 1'b1; end
        check("abort no done", 64'(saw_done), 64'h0);
        @(negedge clock);
        reset = 1'b1;
        run_check("after reset m3x4", 32'hFFFF_FFFD, 32'd4, 64'hFFFF_FFFF_FFFF_FFF4, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: rb = 32'h7FFF_FFFF;
                2: ra = '0;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_check("random", ra, rb, ref_mul(ra, rb), (n % 50) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
